rmi_spi_cmd_decoder: RTL and testbench
======================================

Name: rmi_spi_cmd_decoder

Overview:
Transaction layer directly downstream of the SPI slave PHY, in the spi_clk domain. Consumes received bytes (spi_rx_vld/spi_rx_data) and frame boundaries (chip select). Decodes a command/address/data protocol into single-cycle register-bus reads and writes. Returns read data to the PHY through its spi_tx_en/spi_tx_data/spi_tx_rdy handshake.

Parameters:
ADDR_W, 8, register address width; address byte zero-extended or truncated to ADDR_W
RD_LAT, 1, cycles from reg_re to valid reg_rdata (1..3)

Ports:
spi_clk  in  1  system clock; all logic on rising edge
spi_rst  in  1  reset; synchronous, active-high
i_csn  in  1  raw SPI chip select (async); synchronized internally
spi_rx_vld  in  1  one-cycle pulse: byte received
spi_rx_data  in  8  received byte, valid with spi_rx_vld
spi_tx_rdy  in  1  PHY can accept next TX byte
spi_tx_en  out  1  one-cycle load strobe to PHY
spi_tx_data  out  8  TX byte, valid with spi_tx_en
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid RD_LAT cycles after reg_re
busy  out  1  frame in progress (csn_s low)
proto_err  out  1  sticky error, cleared on next frame start

Behaviour:
- Reset: all outputs 0, state IDLE, csn synchronizer preset to 1 (deasserted).
- i_csn passes through a 2-FF synchronizer to give csn_s; frame start = csn_s falling, frame end = csn_s rising.
- spi_rx_vld ignored while csn_s=1; this covers the PHY's power-up rx_vld glitch.
- Frame format: byte0 = command, bit7 = 1 read / 0 write, bits[6:0] must be 0. byte1 = start address. Bytes 2..n = write data, or dummies for a read.
- States: IDLE, CMD, ADDR, WDATA, RFETCH, RLOAD, RWAIT, ERR.
- IDLE -> CMD on frame start; proto_err cleared the same cycle.
- CMD: on rx_vld, latch rw. If bits[6:0] != 0, set proto_err and go to ERR; otherwise go to ADDR.
- ADDR: on rx_vld, load reg_addr. Write goes to WDATA; read goes to RFETCH.
- WDATA: on rx_vld, reg_wdata <= byte and reg_we=1 for exactly one cycle, the cycle after rx_vld. Address advances after the strobe (see Optional Feature).
- RFETCH: reg_re=1 for one cycle. reg_rdata is captured after RD_LAT cycles into a tx holding register; go to RLOAD.
- RLOAD: wait for spi_tx_rdy=1, then spi_tx_en=1 for one cycle with spi_tx_data = held byte; go to RWAIT.
- RWAIT: on rx_vld (dummy byte clocked), advance address and go to RFETCH.
- Read throughput: the first data byte returns in the byte slot after the address byte; the PHY then transmits it on the following slot.
- ERR: ignore bytes until frame end.
- Frame end in any state -> IDLE next cycle. This aborts any pending fetch/load with no spi_tx_en. A reg_we/reg_re already issued completes; no new strobe is issued.
- Address wraps modulo 2^ADDR_W.
- rx_vld arriving in RFETCH/RLOAD (host too fast): set proto_err and stay in the read flow; that byte is dropped.
- reg_we and reg_re are never both 1; at most one strobe per received byte.
- spi_rst mid-frame: immediate IDLE. A frame already in progress is not recognised until csn_s goes high and then low again.

Optional Feature:
Macro RMI_SPI_ADDR_AUTOINC_EN.
- Defined: reg_addr increments by 1 after each write strobe and after each read byte is acknowledged (RWAIT rx_vld). Supports burst access.
- Undefined: reg_addr stays at the start address for the whole frame (FIFO-port style); all other behaviour is identical.

Decomposition:
- Package rmi_spi_pkg holds the state enum and the command field constants: RW bit index 7, reserved mask 7'h7F, CMD_READ=1'b1.
- One natural sub-module: rmi_sync_2ff (parameterised reset value) for the csn synchronizer, shared with other CDC points.

Test Plan:
1. Write frame: cmd 0x00, addr 0x10, data 0xA5, 0x5A -> reg_we pulses with (0x10, 0xA5) then (0x11, 0x5A) when autoinc is defined, or both at 0x10 when undefined; proto_err=0.
2. Read frame: cmd 0x80, addr 0x20, two dummy bytes, reg_rdata model = addr^0xFF -> reg_re at 0x20 and 0x21; spi_tx_en carries 0xDF then 0xDE, each only while spi_tx_rdy=1.
3. Bad command 0x81 -> proto_err=1, no reg_we/reg_re for the rest of the frame; next frame start clears proto_err.
4. Wrap: write burst at addr 0xFF with ADDR_W=8 and autoinc -> second write lands at 0x00.
5. Abort: i_csn deasserted after the address byte of a read, before spi_tx_rdy -> no spi_tx_en, state IDLE within 3 cycles, busy=0.
6. Reset: spi_rx_vld held 1 in the cycle after spi_rst release with i_csn high -> no strobes, all outputs 0.

Source files
------------

// File: rtl/rmi_spi_cmd_decoder_pkg.sv
// Shared types and command-field constants for the SPI command decoder.
package rmi_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RFETCH,
    ST_RLOAD,
    ST_RWAIT,
    ST_ERR
  } state_e;

  localparam int         CMD_RW_BIT    = 7;
  localparam logic [6:0] CMD_RSVD_MASK = 7'h7F;
  localparam logic       CMD_READ      = 1'b1;

  // A command byte is legal only when all reserved bits are zero.
  function automatic logic cmd_rsvd_ok(input logic [7:0] cmd);
    return (cmd[6:0] & CMD_RSVD_MASK) == 7'h00;
  endfunction

endpackage

// File: rtl/rmi_spi_cmd_decoder_if.sv
// Byte stream to/from the SPI PHY plus the single-cycle register bus.
// slave: the decoder side; master: the PHY / register-file side.
interface rmi_spi_cmd_decoder_if #(
  parameter int ADDR_W = 8
);
  logic              spi_rx_vld;
  logic [7:0]        spi_rx_data;
  logic              spi_tx_rdy;
  logic              spi_tx_en;
  logic [7:0]        spi_tx_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport slave (
    input  spi_rx_vld, spi_rx_data, spi_tx_rdy, reg_rdata,
    output spi_tx_en, spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport master (
    output spi_rx_vld, spi_rx_data, spi_tx_rdy, reg_rdata,
    input  spi_tx_en, spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/rmi_spi_cmd_decoder_sync.sv
// Two-flop synchronizer with a configurable reset value, for async inputs.
module rmi_sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to resolve metastability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/rmi_spi_cmd_decoder.sv
// SPI transaction layer: decodes cmd/addr/data frames into register-bus
// reads and writes and returns read data through the PHY TX handshake.
// Build option: define RMI_SPI_ADDR_AUTOINC_EN for burst address increment;
// without it the address stays at the start address for the whole frame.
module rmi_spi_cmd_decoder
  import rmi_spi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   spi_clk,
  input  logic                   spi_rst,
  input  logic                   i_csn,
  rmi_spi_cmd_decoder_if.slave   bus,
  output logic                   busy,
  output logic                   proto_err
);
  logic csn_s;
  logic rx;
  logic frame_start;
  logic tx_en;

  logic [1:0]        settle_q;
  logic              csn_prev_q;
  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        hold_q, hold_d;
  logic [1:0]        lat_q, lat_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              re_q, re_d;

  rmi_sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_csn_sync (
    .clk_i (spi_clk),
    .rst_i (spi_rst),
    .d_i   (i_csn),
    .q_o   (csn_s)
  );

  // Edge history starts only once the synchronizer holds post-reset samples,
  // so a frame already running across reset never looks like a new start.
  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      settle_q   <= 2'd0;
      csn_prev_q <= 1'b0;
    end else if (settle_q != 2'd2) begin
      settle_q   <= settle_q + 2'd1;
    end else begin
      csn_prev_q <= csn_s;
    end
  end

  assign frame_start = csn_prev_q && !csn_s;
  assign rx          = bus.spi_rx_vld && !csn_s;
  assign tx_en       = (state_q == ST_RLOAD) && bus.spi_tx_rdy && !csn_s;

  // State and datapath registers.
  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      hold_q  <= 8'h00;
      lat_q   <= 2'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  // Next-state decode; strobes are registered so they land the cycle after
  // the triggering byte.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    lat_d   = lat_q;
    err_d   = err_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
`ifdef RMI_SPI_ADDR_AUTOINC_EN
    if (we_q) addr_d = addr_q + ADDR_W'(1);
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_CMD;
          err_d   = 1'b0;
        end
      end
      ST_CMD: begin
        if (rx) begin
          rw_d = bus.spi_rx_data[CMD_RW_BIT];
          if (!cmd_rsvd_ok(bus.spi_rx_data)) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (rx) begin
          addr_d = ADDR_W'(bus.spi_rx_data);
          if (rw_q == CMD_READ) begin
            state_d = ST_RFETCH;
            re_d    = 1'b1;
            lat_d   = 2'd0;
          end else begin
            state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (rx) begin
          wdata_d = bus.spi_rx_data;
          we_d    = 1'b1;
        end
      end
      ST_RFETCH: begin
        if (rx) err_d = 1'b1;
        if (lat_q == 2'(RD_LAT)) begin
          hold_d  = bus.reg_rdata;
          state_d = ST_RLOAD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_RLOAD: begin
        if (rx) err_d = 1'b1;
        if (bus.spi_tx_rdy) state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (rx) begin
`ifdef RMI_SPI_ADDR_AUTOINC_EN
          addr_d = addr_q + ADDR_W'(1);
`endif
          state_d = ST_RFETCH;
          re_d    = 1'b1;
          lat_d   = 2'd0;
        end
      end
      default: ;
    endcase
    // Chip-select release wins over everything and suppresses new strobes.
    if (state_q != ST_IDLE && csn_s) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end
  end

  assign bus.spi_tx_en   = tx_en;
  assign bus.spi_tx_data = tx_en ? hold_q : 8'h00;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_re      = re_q;
  assign busy            = (state_q != ST_IDLE);
  assign proto_err       = err_q;
endmodule

// File: tb/tb_rmi_spi_cmd_decoder.sv
// Randomized self-checking bench for rmi_spi_cmd_decoder.
module tb_rmi_spi_cmd_decoder;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;
`ifdef RMI_SPI_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic spi_clk = 1'b0;
  logic spi_rst = 1'b1;
  logic i_csn   = 1'b1;
  logic busy;
  logic proto_err;

  rmi_spi_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

  rmi_spi_cmd_decoder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .spi_clk   (spi_clk),
    .spi_rst   (spi_rst),
    .i_csn     (i_csn),
    .bus       (bus.slave),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 spi_clk = ~spi_clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] wr_log[$];
  logic [7:0]  re_log[$];
  logic [7:0]  tx_log[$];

  // Register file model: read data is ~address, valid exactly RD_LAT cycles
  // after reg_re; any other cycle presents 0.
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge spi_clk) begin
    rd_pipe[0] <= bus.reg_re ? ~bus.reg_addr : 8'h00;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.reg_rdata = rd_pipe[RD_LAT-1];

  // PHY TX-ready model: ready one cycle in three while enabled.
  bit rdy_en = 1'b0;
  int cyc    = 0;
  int ph;
  initial begin
    ph = $urandom_range(0, 2);
    bus.spi_tx_rdy = 1'b0;
    forever begin
      @(posedge spi_clk);
      cyc++;
      #1 bus.spi_tx_rdy = rdy_en && ((cyc % 3) == ph);
    end
  end

  // Bus monitor.
  always @(negedge spi_clk) begin
    if (!spi_rst) begin
      if (bus.reg_we) wr_log.push_back({bus.reg_addr, bus.reg_wdata});
      if (bus.reg_re) re_log.push_back(bus.reg_addr);
      if (bus.reg_we || bus.reg_re) begin
        checks++;
        if (bus.reg_we && bus.reg_re) begin
          errors++;
          $display("FAIL strobe_exclusive: we=%b re=%b required not both 1", bus.reg_we, bus.reg_re);
        end
      end
      if (bus.spi_tx_en) begin
        tx_log.push_back(bus.spi_tx_data);
        checks++;
        if (bus.spi_tx_rdy !== 1'b1) begin
          errors++;
          $display("FAIL tx_en_needs_rdy: spi_tx_rdy=%b required 1", bus.spi_tx_rdy);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference address for the k-th data byte of a frame starting at 'start'.
  function automatic logic [7:0] exp_addr(input logic [7:0] start, input int k);
    return AUTOINC ? 8'((int'(start) + k) % 256) : start;
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    re_log.delete();
    tx_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge spi_clk);
    #1 bus.spi_rx_vld = 1'b1;
    bus.spi_rx_data = b;
    @(posedge spi_clk);
    #1 bus.spi_rx_vld = 1'b0;
  endtask

  task automatic frame_begin();
    @(posedge spi_clk);
    #1 i_csn = 1'b0;
    repeat (4) @(posedge spi_clk);
  endtask

  task automatic frame_end();
    @(posedge spi_clk);
    #1 i_csn = 1'b1;
    repeat (6) @(posedge spi_clk);
  endtask

  task automatic run_write(input logic [7:0] a, input logic [7:0] d[$]);
    frame_begin();
    send_byte(8'h00, $urandom_range(10, 16));
    send_byte(a, $urandom_range(10, 16));
    foreach (d[k]) send_byte(d[k], $urandom_range(10, 16));
    frame_end();
  endtask

  // Read frame of n dummy bytes; chip select rises right after the last one.
  task automatic run_read(input logic [7:0] a, input int n);
    rdy_en = 1'b1;
    frame_begin();
    send_byte(8'h80, $urandom_range(10, 16));
    send_byte(a, $urandom_range(10, 16));
    for (int k = 0; k < n; k++) send_byte(8'($urandom), $urandom_range(10, 16));
    i_csn = 1'b1;
    repeat (8) @(posedge spi_clk);
    rdy_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] outs;
    spi_rst = 1'b1;
    i_csn = 1'b1;
    bus.spi_rx_vld = 1'b0;
    bus.spi_rx_data = 8'h00;
    repeat (3) @(posedge spi_clk);
    @(negedge spi_clk);
    outs = {bus.reg_we, bus.reg_re, bus.spi_tx_en, bus.spi_tx_data, bus.reg_addr, bus.reg_wdata, busy, proto_err};
    checks++;
    if (outs !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(posedge spi_clk);
    #1 spi_rst = 1'b0;
    @(posedge spi_clk);
    #1 bus.spi_rx_vld = 1'b1;
    bus.spi_rx_data = 8'h80;
    @(posedge spi_clk);
    #1 bus.spi_rx_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge spi_clk);
      outs = {bus.reg_we, bus.reg_re, bus.spi_tx_en, bus.spi_tx_data, bus.reg_addr, bus.reg_wdata, busy, proto_err};
      checks++;
      if (outs !== 29'h0) begin
        errors++;
        $display("FAIL post_reset_rxvld_cycle%0d: got %h required 0", c, outs);
      end
    end
  endtask

  task automatic test_write();
    logic [7:0] d[$];
    logic [7:0] a;
    for (int f = 0; f < 4; f++) begin
      clear_logs();
      d.delete();
      if (f == 0) begin
        a = 8'h10;
        d.push_back(8'hA5);
        d.push_back(8'h5A);
      end else begin
        a = 8'($urandom);
        repeat ($urandom_range(1, 4)) d.push_back(8'($urandom));
      end
      run_write(a, d);
      checks++;
      if (wr_log.size() != d.size()) begin
        errors++;
        $display("FAIL write_count f%0d: got %0d required %0d", f, wr_log.size(), d.size());
      end else begin
        foreach (d[k]) begin
          checks++;
          if (wr_log[k] !== {exp_addr(a, k), d[k]}) begin
            errors++;
            $display("FAIL write_%0d_%0d: got addr/data %h required %h", f, k, wr_log[k], {exp_addr(a, k), d[k]});
          end
        end
      end
      checks++;
      if (re_log.size() != 0 || proto_err !== 1'b0) begin
        errors++;
        $display("FAIL write_clean f%0d: reads=%0d proto_err=%b required 0/0", f, re_log.size(), proto_err);
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] a;
    int n;
    for (int f = 0; f < 3; f++) begin
      clear_logs();
      if (f == 0) begin
        a = 8'h20;
        n = 2;
      end else begin
        a = 8'($urandom_range(0, 8'hF0));
        n = $urandom_range(1, 3);
      end
      run_read(a, n);
      checks++;
      if (tx_log.size() != n) begin
        errors++;
        $display("FAIL read_tx_count f%0d: got %0d required %0d", f, tx_log.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (tx_log[k] !== ~exp_addr(a, k)) begin
            errors++;
            $display("FAIL read_tx_%0d_%0d: got %h required %h", f, k, tx_log[k], ~exp_addr(a, k));
          end
        end
      end
      // The dummy byte that ends the frame may already have launched one
      // more fetch before chip select is seen; that one completes silently.
      checks++;
      if (re_log.size() < n || re_log.size() > n + 1) begin
        errors++;
        $display("FAIL read_re_count f%0d: got %0d required %0d or %0d", f, re_log.size(), n, n + 1);
      end else begin
        foreach (re_log[k]) begin
          checks++;
          if (re_log[k] !== exp_addr(a, k)) begin
            errors++;
            $display("FAIL read_addr_%0d_%0d: got %h required %h", f, k, re_log[k], exp_addr(a, k));
          end
        end
      end
      checks++;
      if (wr_log.size() != 0 || proto_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL read_clean f%0d: writes=%0d proto_err=%b busy=%b required 0/0/0", f, wr_log.size(), proto_err, busy);
      end
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] cmd;
    for (int f = 0; f < 3; f++) begin
      clear_logs();
      cmd = (f == 0) ? 8'h81 : {1'($urandom), 7'($urandom_range(1, 127))};
      frame_begin();
      send_byte(cmd, $urandom_range(10, 16));
      @(negedge spi_clk);
      checks++;
      if (proto_err !== 1'b1) begin
        errors++;
        $display("FAIL bad_cmd_err cmd=%h: got %b required 1", cmd, proto_err);
      end
      repeat (3) send_byte(8'($urandom), $urandom_range(10, 16));
      frame_end();
      checks++;
      if (wr_log.size() + re_log.size() + tx_log.size() != 0) begin
        errors++;
        $display("FAIL bad_cmd_nostrobe cmd=%h: got %0d strobes required 0", cmd, wr_log.size() + re_log.size() + tx_log.size());
      end
      checks++;
      if (proto_err !== 1'b1) begin
        errors++;
        $display("FAIL bad_cmd_sticky: got %b required 1", proto_err);
      end
      frame_begin();
      @(negedge spi_clk);
      checks++;
      if (proto_err !== 1'b0) begin
        errors++;
        $display("FAIL bad_cmd_clear: got %b required 0", proto_err);
      end
      frame_end();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d[$];
    clear_logs();
    d.push_back(8'h3C);
    d.push_back(8'hC3);
    run_write(8'hFF, d);
    checks++;
    if (wr_log.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d required 2", wr_log.size());
    end else begin
      checks++;
      if (wr_log[1] !== {(AUTOINC ? 8'h00 : 8'hFF), 8'hC3}) begin
        errors++;
        $display("FAIL wrap_second: got %h required %h", wr_log[1], {(AUTOINC ? 8'h00 : 8'hFF), 8'hC3});
      end
    end
  endtask

  task automatic test_abort();
    clear_logs();
    rdy_en = 1'b0;
    frame_begin();
    send_byte(8'h80, $urandom_range(10, 16));
    send_byte(8'h40, $urandom_range(10, 16));
    i_csn = 1'b1;
    repeat (3) @(posedge spi_clk);
    @(negedge spi_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b required 0", busy);
    end
    rdy_en = 1'b1;
    repeat (10) @(posedge spi_clk);
    rdy_en = 1'b0;
    checks++;
    if (tx_log.size() != 0 || wr_log.size() != 0 || re_log.size() > 1) begin
      errors++;
      $display("FAIL abort_nostrobe: tx=%0d we=%0d re=%0d required 0/0/<=1", tx_log.size(), wr_log.size(), re_log.size());
    end
  endtask

  task automatic test_host_too_fast();
    clear_logs();
    rdy_en = 1'b0;
    frame_begin();
    send_byte(8'h80, $urandom_range(10, 16));
    send_byte(8'h33, $urandom_range(10, 16));
    send_byte(8'h00, 1);
    @(negedge spi_clk);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL fast_err: got %b required 1", proto_err);
    end
    rdy_en = 1'b1;
    repeat (8) @(posedge spi_clk);
    rdy_en = 1'b0;
    checks++;
    if (tx_log.size() != 1 || re_log.size() != 1) begin
      errors++;
      $display("FAIL fast_flow: tx=%0d re=%0d required 1/1", tx_log.size(), re_log.size());
    end else begin
      checks++;
      if (tx_log[0] !== 8'hCC) begin
        errors++;
        $display("FAIL fast_tx: got %h required cc", tx_log[0]);
      end
    end
    frame_end();
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    frame_begin();
    send_byte(8'h00, $urandom_range(10, 16));
    @(posedge spi_clk);
    #1 spi_rst = 1'b1;
    @(posedge spi_clk);
    #1 spi_rst = 1'b0;
    send_byte(8'h55, $urandom_range(10, 16));
    send_byte(8'h66, $urandom_range(10, 16));
    @(negedge spi_clk);
    checks++;
    if (busy !== 1'b0 || wr_log.size() != 0 || re_log.size() != 0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: busy=%b we=%0d re=%0d err=%b required 0/0/0/0", busy, wr_log.size(), re_log.size(), proto_err);
    end
    frame_end();
  endtask

  task automatic test_back_to_back();
    logic [7:0] wa;
    logic [7:0] ra;
    logic [7:0] wd;
    clear_logs();
    wa = 8'($urandom);
    wd = 8'($urandom);
    ra = 8'($urandom_range(0, 8'hF0));
    frame_begin();
    send_byte(8'h00, $urandom_range(10, 16));
    send_byte(wa, $urandom_range(10, 16));
    send_byte(wd, $urandom_range(10, 16));
    @(posedge spi_clk);
    #1 i_csn = 1'b1;
    repeat (3) @(posedge spi_clk);
    run_read(ra, 1);
    checks++;
    if (wr_log.size() != 1 || tx_log.size() != 1) begin
      errors++;
      $display("FAIL b2b_counts: we=%0d tx=%0d required 1/1", wr_log.size(), tx_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== {wa, wd} || tx_log[0] !== ~ra) begin
        errors++;
        $display("FAIL b2b_data: wr=%h tx=%h required %h %h", wr_log[0], tx_log[0], {wa, wd}, ~ra);
      end
    end
  endtask

  initial begin
    bus.spi_rx_vld  = 1'b0;
    bus.spi_rx_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_wrap();
    test_abort();
    test_host_too_fast();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
